// File: rtl/clk_div_monitor.sv
// clk_div_monitor: checker for a divide-by-N clock generated in the clk domain.
// Measures period and high time of each divided cycle, flags period, duty and
// stuck faults, declares lock after LOCK_CNT consecutive good periods and keeps
// a saturating fault counter.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   en           monitor enable; low forces IDLE
//   div_in       divided clock, synchronous to clk
//   err_clr      synchronous clear of err_count (wins over an increment)
//   locked       period and duty verified
//   meas_valid   one-cycle pulse when meas_period/meas_high update
//   meas_period  last measured period (clk cycles)
//   meas_high    last measured high time (clk cycles)
//   err_period   one-cycle pulse, period mismatch
//   err_duty     one-cycle pulse, high-time mismatch
//   err_stuck    one-cycle pulse, no rising edge for TIMEOUT cycles
//   lost_lock    one-cycle pulse when locked falls because of a fault
//   err_count    saturating count of fault events
module clk_div_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXP_PERIOD = 10,
    parameter int unsigned EXP_HIGH   = 4,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned TIMEOUT    = 20,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             err_period,
    output logic             err_duty,
    output logic             err_stuck,
    output logic             lost_lock,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_e;

    state_e             state_q;
    logic               div_prev_q;
    logic [CNT_W-1:0]   per_cnt_q;
    logic [CNT_W-1:0]   high_cnt_q;
    logic [GOOD_W-1:0]  good_cnt_q;

    logic rise;
    logic good;
    logic stuck;
    logic checking;
    logic fault;

    assign rise     = div_in & ~div_prev_q;
    assign good     = (per_cnt_q == CNT_W'(EXP_PERIOD)) && (high_cnt_q == CNT_W'(EXP_HIGH));
    assign stuck    = ~rise && (per_cnt_q == CNT_W'(TIMEOUT));
    assign checking = en && ((state_q == CHECK) || (state_q == LOCKED));
    // A bad period (period and/or duty) or a stall is a single fault event.
    assign fault    = checking && (rise ? ~good : stuck);

    // Edge detect plus free-running period / high-time counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_prev_q <= 1'b0;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
        end else begin
            div_prev_q <= div_in;
            if (rise) begin
                per_cnt_q  <= CNT_W'(1);
                high_cnt_q <= CNT_W'(1);
            end else begin
                if (per_cnt_q != CNT_MAX) begin
                    per_cnt_q <= per_cnt_q + CNT_W'(1);
                end
                if (div_in && (high_cnt_q != CNT_MAX)) begin
                    high_cnt_q <= high_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Lock FSM with registered measurement and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            good_cnt_q  <= '0;
            locked      <= 1'b0;
            meas_valid  <= 1'b0;
            meas_period <= '0;
            meas_high   <= '0;
            err_period  <= 1'b0;
            err_duty    <= 1'b0;
            err_stuck   <= 1'b0;
            lost_lock   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            err_period <= 1'b0;
            err_duty   <= 1'b0;
            err_stuck  <= 1'b0;
            lost_lock  <= 1'b0;
            if (!en) begin
                state_q    <= IDLE;
                locked     <= 1'b0;
                good_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= ACQ;
                    // The period ending at the first rise is partial: no measurement.
                    ACQ: begin
                        if (rise) begin
                            state_q <= CHECK;
                        end
                    end
                    CHECK, LOCKED: begin
                        if (rise) begin
                            meas_valid  <= 1'b1;
                            meas_period <= per_cnt_q;
                            meas_high   <= high_cnt_q;
                            err_period  <= per_cnt_q != CNT_W'(EXP_PERIOD);
                            err_duty    <= high_cnt_q != CNT_W'(EXP_HIGH);
                            if (good) begin
                                if (state_q == CHECK) begin
                                    if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
                                        state_q    <= LOCKED;
                                        locked     <= 1'b1;
                                        good_cnt_q <= GOOD_W'(LOCK_CNT);
                                    end else begin
                                        good_cnt_q <= good_cnt_q + GOOD_W'(1);
                                    end
                                end
                            end else begin
                                state_q    <= CHECK;
                                good_cnt_q <= '0;
                                if (state_q == LOCKED) begin
                                    locked    <= 1'b0;
                                    lost_lock <= 1'b1;
                                end
                            end
                        end else if (stuck) begin
                            // Leaving for ACQ stops the stall from being re-flagged.
                            err_stuck  <= 1'b1;
                            state_q    <= ACQ;
                            good_cnt_q <= '0;
                            if (state_q == LOCKED) begin
                                locked    <= 1'b0;
                                lost_lock <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Saturating fault counter; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (fault && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed and randomized div_in streams checked every
// cycle against a cycle-count based reference model of the monitor.
module tb_clk_div_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       div_in;
    logic       err_clr;
    logic       locked;
    logic       meas_valid;
    logic [7:0] meas_period;
    logic [7:0] meas_high;
    logic       err_period;
    logic       err_duty;
    logic       err_stuck;
    logic       lost_lock;
    logic [7:0] err_count;

    clk_div_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .div_in      (div_in),
        .err_clr     (err_clr),
        .locked      (locked),
        .meas_valid  (meas_valid),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .err_period  (err_period),
        .err_duty    (err_duty),
        .err_stuck   (err_stuck),
        .lost_lock   (lost_lock),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the clk edge index of the last rise and the high samples seen
    // since; the lock condition is a streak of good periods.
    localparam int EXP_P = 10, EXP_H = 4, NEED = 3, TMO = 20, SAT = 255;

    int cyc = 0, last_rise = 0, highs = 0, streak = 0;
    int mode = 0;            // 0 idle, 1 waiting first rise, 2 verifying, 3 locked
    bit m_prev = 0;
    int m_locked = 0, m_valid = 0, m_per = 0, m_high = 0;
    int m_eper = 0, m_eduty = 0, m_stuck = 0, m_lost = 0, m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rise = cyc; highs = 0; streak = 0; mode = 0; m_prev = 0;
            m_locked = 0; m_valid = 0; m_per = 0; m_high = 0;
            m_eper = 0; m_eduty = 0; m_stuck = 0; m_lost = 0; m_cnt = 0;
        end else begin
            int  per;
            bit  rise, fault;
            per   = (cyc - last_rise > SAT) ? SAT : cyc - last_rise;
            rise  = div_in && !m_prev;
            fault = 0;
            m_valid = 0; m_eper = 0; m_eduty = 0; m_stuck = 0; m_lost = 0;
            if (!en) begin
                mode = 0; m_locked = 0; streak = 0;
            end else if (mode == 0) begin
                mode = 1;
            end else if (mode == 1) begin
                if (rise) mode = 2;
            end else if (rise) begin
                m_valid = 1; m_per = per; m_high = highs;
                m_eper  = (per != EXP_P); m_eduty = (highs != EXP_H);
                if (!m_eper && !m_eduty) begin
                    if (mode == 2) begin
                        streak++;
                        if (streak >= NEED) begin mode = 3; m_locked = 1; end
                    end
                end else begin
                    fault = 1; streak = 0;
                    if (mode == 3) m_lost = 1;
                    mode = 2; m_locked = 0;
                end
            end else if (per == TMO) begin
                fault = 1; m_stuck = 1; streak = 0;
                if (mode == 3) m_lost = 1;
                mode = 1; m_locked = 0;
            end
            if (err_clr) m_cnt = 0;
            else if (fault && m_cnt < SAT) m_cnt++;
            if (rise) begin last_rise = cyc; highs = 1; end
            else if (div_in && highs < SAT) highs++;
            m_prev = div_in;
            cyc++;
        end
    end

    // Every-cycle comparison of all outputs, away from the active edge.
    always @(negedge clk) begin
        check_eq("locked",      32'(locked),      32'(m_locked));
        check_eq("meas_valid",  32'(meas_valid),  32'(m_valid));
        check_eq("meas_period", 32'(meas_period), 32'(m_per));
        check_eq("meas_high",   32'(meas_high),   32'(m_high));
        check_eq("err_period",  32'(err_period),  32'(m_eper));
        check_eq("err_duty",    32'(err_duty),    32'(m_eduty));
        check_eq("err_stuck",   32'(err_stuck),   32'(m_stuck));
        check_eq("lost_lock",   32'(lost_lock),   32'(m_lost));
        check_eq("err_count",   32'(err_count),   32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    bit rand_clr    = 0;
    bit clr_on_rise = 0;

    task automatic step(input logic d, input logic clr);
        @(posedge clk);
        #2;
        div_in  = d;
        err_clr = clr;
    endtask

    task automatic drive_period(input int p, input int h);
        for (int i = 0; i < p; i++) begin
            step(logic'(i < h),
                 logic'((i == 0 && clr_on_rise) || (rand_clr && $urandom_range(0, 39) == 0)));
        end
        clr_on_rise = 0;
    endtask

    task automatic nominal(input int n);
        for (int i = 0; i < n; i++) drive_period(10, 4);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; div_in = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1; en = 1'b1;

        // Nominal stream locks on the 4th rise with no faults.
        stall(2);
        nominal(6);
        check_eq("nominal_locked", 32'(locked), 32'd1);
        check_eq("nominal_errcnt", 32'(err_count), 32'd0);

        // Duty fault, period faults, both at once; relock after each.
        drive_period(10, 5); nominal(4);
        drive_period(11, 4); nominal(4);
        drive_period(11, 5); nominal(4);
        check_eq("relock", 32'(locked), 32'd1);
        check_eq("fault_count", 32'(err_count), 32'd3);

        // Stall while locked, then restart.
        stall(30);
        check_eq("stall_unlocked", 32'(locked), 32'd0);
        nominal(6);
        check_eq("stall_relock", 32'(locked), 32'd1);

        // Saturation of the fault counter, then clear against a fault.
        step(1'b0, 1'b1);
        for (int i = 0; i < 260; i++) drive_period(9, 4);
        check_eq("err_sat", 32'(err_count), 32'd255);
        clr_on_rise = 1;
        drive_period(10, 4);
        check_eq("clr_wins", 32'(err_count), 32'd0);

        // Enable dropped while locked.
        nominal(5);
        check_eq("pre_en_locked", 32'(locked), 32'd1);
        en = 1'b0;
        drive_period(10, 4);
        check_eq("en_off_unlocked", 32'(locked), 32'd0);
        en = 1'b1;
        nominal(5);

        // Randomized mix of good, bad, stalled and disabled stretches.
        rand_clr = 1;
        for (int k = 0; k < 300; k++) begin
            int r, p;
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                drive_period(10, 4);
            end else if (r < 85) begin
                p = int'($urandom_range(5, 14));
                drive_period(p, int'($urandom_range(1, p - 1)));
            end else if (r < 92) begin
                stall(int'($urandom_range(21, 40)));
            end else begin
                en = 1'b0;
                drive_period(10, 4);
                en = 1'b1;
            end
        end
        rand_clr = 0;

        // Reset asserted mid-period clears everything at once.
        nominal(5);
        drive_period(5, 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_locked",     32'(locked),      32'd0);
        check_eq("rst_meas_valid", 32'(meas_valid),  32'd0);
        check_eq("rst_meas_per",   32'(meas_period), 32'd0);
        check_eq("rst_meas_high",  32'(meas_high),   32'd0);
        check_eq("rst_err_count",  32'(err_count),   32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        stall(1);
        nominal(6);
        check_eq("post_rst_locked", 32'(locked), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
